// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: machine width, instruction size, reset PC and fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN  = 1'b0;
  localparam fetch_state_t HALT = 1'b1;

  // Controller redirect: unconditional jump, or a branch whose (optionally inverted) condition holds.
  function automatic logic redirect_taken(input logic jump, input logic branch,
                                          input logic branch_neg, input logic cond);
    return jump | (branch & (cond ^ branch_neg));
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous instruction buffer FIFO with flush; flush wins over a same-cycle push.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2 * XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCount);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: in-order memory requests, buffered delivery, redirect with response drop.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect target raises misalign and halts fetch.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            jump,
  input  logic            branch,
  input  logic            branch_neg,
  input  logic            cond,
  input  logic [XLEN-1:0] target,
  output logic            misalign
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthCnt = DEPTH[CW-1:0];
  localparam logic [CW:0]   DepthOcc = DEPTH[CW:0];

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic            redirect, issue, resp, push, pop;
  logic [XLEN-1:0] tgt;
  logic            bad_tgt;
  logic [CW:0]     occ;

  logic [2*XLEN-1:0] buf_rdata;
  logic [CW-1:0]     buf_count;
  logic              buf_full, buf_empty;

  assign redirect = redirect_taken(jump, branch, branch_neg, cond);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt     = target;
  assign bad_tgt = redirect && (target[1:0] != 2'b00);
`else
  logic unused_tgt;
  assign tgt        = {target[XLEN-1:2], 2'b00};
  assign bad_tgt    = 1'b0;
  assign unused_tgt = ^target[1:0];
`endif

  logic unused_full;
  assign unused_full = buf_full;

  assign instr_valid = (state_q == RUN) && !buf_empty;
  assign pop         = instr_valid && instr_ready;

  // A slot leaving the buffer this cycle already counts as free, giving one issue per cycle.
  always_comb begin
    occ      = {1'b0, outst_q} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
    imem_req = !reset && (state_q == RUN) && !redirect && (occ < DepthOcc);
  end

  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;
  // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
  assign resp      = imem_rvalid && (outst_q != '0);
  assign push      = resp && (drop_q == '0) && (state_q == RUN) && !redirect;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    state_d    = state_q;
    misalign_d = misalign_q;
    outst_d    = outst_q + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, resp};
    drop_d     = drop_q;
    // Every request still in flight after a redirect belongs to the abandoned path.
    if (redirect) begin
      drop_d = outst_q - {{(CW-1){1'b0}}, resp};
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
    if (state_q == RUN) begin
      if (redirect) begin
        pc_d      = tgt;
        resp_pc_d = tgt;
      end else begin
        if (issue) begin
          pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
        if (push) begin
          resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);
        end
      end
      if (bad_tgt) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({imem_rdata, resp_pc_q}),
    .rdata_o (buf_rdata),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign instr    = instr_valid ? buf_rdata[2*XLEN-1:XLEN] : '0;
  assign instr_pc = instr_valid ? buf_rdata[XLEN-1:0]      : '0;
  assign misalign = misalign_q;

`ifndef SYNTHESIS
  a_outst_bound : assert property (@(posedge clk) disable iff (reset)
    (outst_q <= DepthCnt) && (drop_q <= outst_q));
  a_req_hold : assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_gnt && !redirect) |=> ((imem_req && $stable(imem_addr)) || redirect));
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries and max outstanding requests (power of two, >=2).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_gnt  input  1  request accepted this cycle (imem_req && imem_gnt = issue).
REQ-008 imem_rvalid  input  1  response valid; responses return in issue order, >=1 cycle after issue.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 instr  output  32  buffered instruction to decode (opcode = instr[6:0], funct3 = instr[14:12], funct7_5 = instr[30]).
REQ-011 instr_pc  output  32  address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc valid.
REQ-013 instr_ready  input  1  decode consumes head entry when instr_valid && instr_ready.
REQ-014 jump  input  1  unconditional redirect from controller.
REQ-015 branch  input  1  conditional branch from controller.
REQ-016 branch_neg  input  1  invert branch condition.
REQ-017 cond  input  1  ALU condition (zero/less-than) for branch.
REQ-018 target  input  32  redirect address.
REQ-019 misalign  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-020 Redirect = jump | (branch & (cond ^ branch_neg)); sampled every cycle, independent of instr_valid.
REQ-021 Fetch PC register; issue uses imem_addr = PC; on issue PC += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-022 imem_req asserted iff state = RUN, no redirect this cycle, and (outstanding + buffer count) < DEPTH.
REQ-023 imem_addr/imem_req held stable while imem_req && !imem_gnt, unless redirect.
REQ-024 Each accepted response writes {imem_rdata, issue address} into buffer; zero-bubble: response in cycle N visible on instr in cycle N+1.
REQ-025 Simultaneous push and pop on a full buffer allowed; count unchanged.
REQ-026 Redirect: PC <= target next cycle, buffer flushed, instr_valid low next cycle, all currently outstanding responses discarded (drop counter loaded with outstanding count minus any response in same cycle), new request issued the cycle after redirect.
REQ-027 Responses arriving while drop counter > 0 decrement it and are not buffered.
REQ-028 Redirect in same cycle as issue: issue suppressed (REQ-022), no orphaned request.
REQ-029 Redirect back-to-back on consecutive cycles: latest target wins; drop counter accumulates correctly.
REQ-030 FSM states: RUN (normal fetch), HALT (no requests, buffer pushes ignored; instr_valid low); RUN -> HALT only via Configuration; HALT exits only on reset.
REQ-031 Outstanding counter and drop counter width clog2(DEPTH)+1; never exceed DEPTH.

Reset
REQ-032 While reset high: PC = RESET_PC, state RUN, buffer empty, counters 0, imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, misalign = 0.
REQ-033 First imem_req asserted in first cycle after reset deasserts; reset mid-transaction discards outstanding responses (responses with counters at 0 before first issue are ignored).

Configuration
REQ-034 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with target[1:0] != 0 sets misalign, flushes buffer, enters HALT.
REQ-035 Macro undefined: misalign tied 0, target[1:0] forced to 2'b00, state never HALT.

Structure
REQ-036 Shared package riscv_pkg holds fetch_state_t (RUN, HALT), XLEN = 32, INSTR_BYTES = 4, RESET_PC default constant.
REQ-037 One sub-module fetch_buf: synchronous FIFO (DEPTH, 64-bit entries), push/pop/flush, count, full, empty; flush has priority over push.

Verification
REQ-038 Reset release, imem_gnt=1, rvalid 1-cycle latency, instr_ready=1 -> addresses 0,4,8,... issued every cycle; instr_pc follows one cycle after response.
REQ-039 instr_ready=0 for 10 cycles -> exactly DEPTH=2 issues, imem_req low thereafter, no data lost on resume.
REQ-040 jump=1, target=32'h100 with 2 outstanding -> both responses dropped, next instr_pc = 32'h100.
REQ-041 branch=1, branch_neg=1, cond=1 -> no redirect; cond=0 -> redirect to target.
REQ-042 imem_gnt=0 for 3 cycles -> imem_addr stable at same value, single issue on grant.
REQ-043 With FETCH_MISALIGN_CHECK_EN, jump to 32'h102 -> misalign=1, imem_req=0 permanently until reset; without macro -> fetch from 32'h100.
